ets_capture_ctrl: RTL and testbench

- Equivalent-time-sampling (ETS) acquisition sequencer for the oscilloscope front end.
- Each trigger event arms one capture pass. The block waits a per-pass fine phase offset, issues a burst of ADC convert strobes, and writes the returned samples into an external capture RAM.
- Sample addresses are interleaved so that a linear RAM read yields the reconstructed high-rate waveform.
- Sits between the trigger comparator/ADC interface and the capture RAM; the display/readout logic consumes `done`.

---
 rtl/ets_capture_ctrl.sv | 152 +++++++++++++++
 tb/tb_ets_capture_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ets_capture_ctrl.sv
// Equivalent-time-sampling capture sequencer: per-trigger phase-offset
// strobe bursts with interleaved capture RAM addressing.
module ets_capture_ctrl #(
    parameter int ADC_W   = 8,
    parameter int PHASES  = 10,
    parameter int POINTS  = 64,
    parameter int PERIOD  = 100,
    parameter int STEP    = 10,
    parameter int ADC_LAT = 3,
    parameter int TIMEOUT = 1000000,
    parameter int AW      = $clog2(PHASES * POINTS),
    parameter int PW      = $clog2(PHASES)
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             abort,
    input  logic             trig,
    input  logic [ADC_W-1:0] adc_data,
    output logic             samp_strobe,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [ADC_W-1:0] wr_data,
    output logic [PW-1:0]    phase,
    output logic             busy,
    output logic             done,
    output logic             trig_timeout
);

    localparam int CW = $clog2(PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int NW = $clog2(POINTS + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        SAMPLE,
        DONE
    } state_t;

    state_t             state, state_nx;
    logic               trig_q;
    logic               trig_edge;
    logic [TW-1:0]      tmo_cnt;
    logic               tmo_hit;
    logic [CW-1:0]      tick;
    logic [CW-1:0]      dly_len;
    logic [NW-1:0]      str_cnt;
    logic [NW-1:0]      cap_cnt;
    logic [ADC_LAT-1:0] lat_sr;
    logic               capture;
    logic               wr_last;
    logic               pass_end;
    logic               last_phase;
    logic               start;

    assign trig_edge  = trig & ~trig_q;
    assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
    assign dly_len    = CW'(phase) * CW'(STEP);
    assign capture    = lat_sr[ADC_LAT-1];
    assign pass_end   = wr_en & wr_last;
    assign last_phase = (phase == PW'(PHASES - 1));
    assign start      = (state == IDLE || state == DONE) && arm && !abort;

    assign busy = (state == ARMED) || (state == DELAY) || (state == SAMPLE);
    assign done = (state == DONE);

    // Strobe on each period boundary; abort kills a strobe in its own cycle.
    assign samp_strobe = (state == SAMPLE) && (tick == '0)
                      && (str_cnt < NW'(POINTS)) && !abort;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (arm) state_nx = ARMED;
            ARMED: begin
                if (trig_edge || tmo_hit)
                    state_nx = (phase == '0) ? SAMPLE : DELAY;
            end
            DELAY:  if (tick == dly_len - 1'b1) state_nx = SAMPLE;
            SAMPLE: if (pass_end) state_nx = last_phase ? DONE : ARMED;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            trig_q       <= 1'b0;
            tmo_cnt      <= '0;
            tick         <= '0;
            str_cnt      <= '0;
            cap_cnt      <= '0;
            lat_sr       <= '0;
            wr_last      <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            phase        <= '0;
            trig_timeout <= 1'b0;
        end else begin
            state  <= state_nx;
            trig_q <= trig;

            if (state == ARMED && state_nx == ARMED)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;

            if (state_nx != state || !(state == DELAY || state == SAMPLE))
                tick <= '0;
            else if (state == SAMPLE && tick == CW'(PERIOD - 1))
                tick <= '0;
            else
                tick <= tick + 1'b1;

            if (state != SAMPLE)
                str_cnt <= '0;
            else if (samp_strobe)
                str_cnt <= str_cnt + 1'b1;

            // Strobe ages through the ADC latency, then its sample is written.
            if (abort)
                lat_sr <= '0;
            else
                lat_sr <= (lat_sr << 1) | ADC_LAT'(samp_strobe);

            wr_en <= capture && !abort;
            if (state != SAMPLE) begin
                cap_cnt <= '0;
            end else if (capture) begin
                cap_cnt <= cap_cnt + 1'b1;
                wr_last <= (cap_cnt == NW'(POINTS - 1));
                wr_data <= adc_data;
                wr_addr <= AW'(cap_cnt) * AW'(PHASES) + AW'(phase);
            end

            if (abort || start)
                phase <= '0;
            else if (state == SAMPLE && pass_end && !last_phase)
                phase <= phase + 1'b1;

            if (start)
                trig_timeout <= 1'b0;
            else if (state == ARMED && tmo_hit && !trig_edge && !abort)
                trig_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ets_capture_ctrl.sv
// Randomized bench for ets_capture_ctrl against a schedule-based
// reference model of the acquisition timing.
module tb_ets_capture_ctrl;

    localparam int ADC_W   = 8;
    localparam int PHASES  = 4;
    localparam int POINTS  = 8;
    localparam int PERIOD  = 20;
    localparam int STEP    = 5;
    localparam int ADC_LAT = 3;
    localparam int TIMEOUT = 200;
    localparam int AW      = 5;
    localparam int PW      = 2;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    logic             sys_clk  = 1'b0;
    logic             rst_n    = 1'b0;
    logic             arm      = 1'b0;
    logic             abort    = 1'b0;
    logic             trig     = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic             samp_strobe;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [ADC_W-1:0] wr_data;
    logic [PW-1:0]    phase;
    logic             busy;
    logic             done;
    logic             trig_timeout;

    ets_capture_ctrl #(
        .ADC_W(ADC_W), .PHASES(PHASES), .POINTS(POINTS),
        .PERIOD(PERIOD), .STEP(STEP), .ADC_LAT(ADC_LAT),
        .TIMEOUT(TIMEOUT), .AW(AW), .PW(PW)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .arm(arm), .abort(abort),
        .trig(trig), .adc_data(adc_data), .samp_strobe(samp_strobe),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .phase(phase), .busy(busy), .done(done),
        .trig_timeout(trig_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: acquisition mode plus the trigger cycle of the pass.
    int          m_mode  = M_IDLE;
    int          m_phase = 0;
    int          m_wait  = 0;
    int          m_t0    = 0;
    int          mc      = 0;
    bit          m_tt    = 1'b0;
    bit          m_tprev = 1'b0;
    logic [7:0]  adc_hist [0:16383];
    logic [31:0] wmask   = '0;
    int          wdup    = 0;

    function automatic int slot(input int c, input int t0, input int p,
                                input int off);
        int d;
        d = c - (t0 + 1 + p * STEP + off);
        if (d < 0 || d % PERIOD != 0 || d / PERIOD >= POINTS) return -1;
        return d / PERIOD;
    endfunction

    always @(negedge sys_clk) begin : model
        int ks, kw, src;
        bit edge_s;
        logic [31:0] ev, gv;
        adc_hist[mc & 16383] = adc_data;
        ks = (m_mode == M_RUN) ? slot(mc, m_t0, m_phase, 0) : -1;
        kw = (m_mode == M_RUN) ? slot(mc, m_t0, m_phase, ADC_LAT + 1) : -1;
        ev = '0;
        ev[6] = (ks >= 0) && !abort;
        ev[5] = (kw >= 0);
        ev[4] = (m_mode == M_ARM) || (m_mode == M_RUN);
        ev[3] = (m_mode == M_DONE);
        ev[2] = m_tt;
        ev[1:0] = m_phase[1:0];
        gv = {25'd0, samp_strobe, wr_en, busy, done, trig_timeout, phase};
        chk("status", gv, ev);
        if (kw >= 0) begin
            src = m_t0 + 1 + m_phase * STEP + kw * PERIOD + ADC_LAT;
            chk("wr_addr", 32'(wr_addr), kw * PHASES + m_phase);
            chk("wr_data", 32'(wr_data), 32'(adc_hist[src & 16383]));
        end
        if (wr_en) begin
            if (wmask[wr_addr]) wdup++;
            wmask[wr_addr] = 1'b1;
        end
        edge_s  = trig && !m_tprev;
        m_tprev = trig;
        if (!rst_n) begin
            m_mode = M_IDLE; m_phase = 0; m_tt = 0;
            m_tprev = 0; m_wait = 0;
        end else if (abort) begin
            m_mode = M_IDLE; m_phase = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: if (arm) begin
                    m_mode = M_ARM; m_phase = 0; m_tt = 0;
                    m_wait = 0; wmask = '0; wdup = 0;
                end
                M_ARM: begin
                    if (edge_s || m_wait == TIMEOUT - 1) begin
                        if (!edge_s) m_tt = 1;
                        m_mode = M_RUN;
                        m_t0 = mc;
                    end else begin
                        m_wait++;
                    end
                end
                M_RUN: begin
                    if (mc == m_t0 + 1 + m_phase * STEP
                        + (POINTS - 1) * PERIOD + ADC_LAT + 1) begin
                        if (m_phase == PHASES - 1) begin
                            m_mode = M_DONE;
                        end else begin
                            m_phase++; m_mode = M_ARM; m_wait = 0;
                        end
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        mc++;
    end

    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            adc_data = ADC_W'($urandom);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic wait_while(input int mode, input int lim,
                              input string tag);
        int n;
        n = 0;
        while (m_mode == mode && n < lim) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(n < lim), 1);
    endtask

    task automatic trig_pulse();
        tick($urandom_range(0, 25));
        trig = 1'b1;
        tick($urandom_range(1, 4));
        trig = 1'b0;
    endtask

    task automatic run_pass(input bit spam);
        trig_pulse();
        if (spam) begin
            tick(30);
            pulse_arm();
            tick(47);
            pulse_arm();
        end
        wait_while(M_RUN, 400, "pass_end");
    endtask

    task automatic run_acq(input bit spam);
        pulse_arm();
        for (int p = 0; p < PHASES; p++) run_pass(spam);
        chk("acq_done", 32'(done), 1);
        chk("acq_busy", 32'(busy), 0);
        chk("acq_phase", 32'(phase), PHASES - 1);
        chk("acq_cover", wmask, 32'hffff_ffff);
        chk("acq_dup", wdup, 0);
    endtask

    task automatic count_quiet(input int n, input string tag);
        int sc;
        sc = 0;
        repeat (n) begin
            tick(1);
            if (samp_strobe || wr_en) sc++;
        end
        chk(tag, sc, 0);
    endtask

    initial begin
        int w, n;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 0);
        count_quiet(500, "idle_quiet");

        run_acq(1'b0);
        run_acq(1'b1);
        repeat (3) run_acq(1'($urandom_range(0, 1)));

        pulse_arm();
        wait_while(M_ARM, 400, "tmo_wait");
        chk("tmo_flag", 32'(trig_timeout), 1);
        trig = 1'b1;
        wait_while(M_RUN, 400, "tmo_pass0");
        chk("tmo_phase", 32'(phase), 1);
        count_quiet(50, "held_no_retrig");
        trig = 1'b0;
        tick(2);
        for (int p = 1; p < PHASES; p++) run_pass(1'b0);
        chk("tmo_done", 32'(done), 1);
        chk("tmo_sticky", 32'(trig_timeout), 1);

        pulse_arm();
        n = 0;
        while (m_wait != TIMEOUT - 1 && n < 300) begin
            tick(1);
            n++;
        end
        chk("edge_tmo_wait", 32'(n < 300), 1);
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        chk("edge_tmo_tt", 32'(trig_timeout), 0);
        wait_while(M_RUN, 400, "edge_tmo_pass");
        for (int p = 1; p < PHASES; p++) run_pass(1'b0);
        chk("edge_tmo_done", 32'(done), 1);
        chk("edge_tmo_tt_end", 32'(trig_timeout), 0);

        pulse_arm();
        trig_pulse();
        w = 0; n = 0;
        while (w < 3 && n < 200) begin
            tick(1);
            n++;
            if (wr_en) w++;
        end
        chk("abort_wait", 32'(n < 200), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        count_quiet(200, "abort_quiet");

        pulse_arm();
        trig_pulse();
        n = 0;
        while (!wr_en && n < 200) begin
            tick(1);
            n++;
        end
        chk("restart_addr", 32'(wr_addr), 0);
        chk("restart_phase", 32'(phase), 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;

        arm = 1'b1;
        abort = 1'b1;
        tick(1);
        arm = 1'b0;
        abort = 1'b0;
        chk("arm_abort_busy", 32'(busy), 0);
        count_quiet(20, "arm_abort_quiet");

        pulse_arm();
        trig_pulse();
        tick(50);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy), 0);
        count_quiet(100, "midrst_quiet");

        run_acq(1'b1);

        tick(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
